// File: rtl/frame_sync_deser.sv
// frame_sync_deser
//   Frame aligner / deserialiser for the deser400 path. An oversampled
//   serial stream is searched for a frame marker, which is one bit followed
//   by SYNC_RUN bits of the opposite value. A phase counter is aligned to
//   the marker's last bit, and every DATA_W enabled cycles the following
//   DATA_W bits are presented on pdata with a one-cycle pvalid strobe.
//   A HUNT/CHECK/LOCKED state machine qualifies lock using consecutive
//   aligned markers (LOCK_CNT) and consecutive misaligned markers
//   (ERR_LIMIT).
//
//   Optional build macro: ERR_COUNT_EN adds a saturating 16-bit count of
//   misaligned markers (err_count) with a clear input (clr_cnt).
//
// Ports
//   clk400    in   bit clock, rising edge
//   reset     in   synchronous, active-high
//   enable    in   cycle qualifier; low holds all state, pvalid forced 0
//   sdata     in   serial data, one bit per enabled cycle
//   clr_cnt   in   (ERR_COUNT_EN only) clears err_count
//   err_count out  (ERR_COUNT_EN only) misaligned-marker count
//   pdata     out  frame data, first-received bit in MSB
//   pvalid    out  one-cycle frame strobe
//   error     out  frame was preceded by a misaligned marker (with pvalid)
//   locked    out  high while in LOCKED

module frame_sync_deser #(
    parameter int DATA_W    = 5,
    parameter int SYNC_RUN  = 5,
    parameter int LOCK_CNT  = 2,
    parameter int ERR_LIMIT = 3
) (
    input  logic              clk400,
    input  logic              reset,
    input  logic              enable,
    input  logic              sdata,
`ifdef ERR_COUNT_EN
    input  logic              clr_cnt,
    output logic [15:0]       err_count,
`endif
    output logic [DATA_W-1:0] pdata,
    output logic              pvalid,
    output logic              error,
    output logic              locked
);

    localparam int SRW = ((DATA_W > SYNC_RUN) ? DATA_W : SYNC_RUN) + 1;
    localparam int PW  = $clog2(DATA_W);
    localparam logic [PW-1:0] PH_LAST  = PW'(DATA_W - 1);
    localparam logic [3:0]    LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [3:0]    ERR_TGT  = 4'(ERR_LIMIT);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_CHECK,
        ST_LOCKED
    } state_t;

    state_t            r_state;
    logic [SRW-1:0]    r_shift;
    logic              r_det;
    logic [PW-1:0]     r_phase;
    logic [3:0]        r_lock_cnt;
    logic [3:0]        r_err_cnt;
    logic              r_pend;
    logic [DATA_W-1:0] r_pdata;
    logic              r_pvalid;
    logic              r_error;
    logic              r_locked;

    logic              w_marker;
    logic              w_sync;

    // Newest SYNC_RUN+1 bits are {b, ~b repeated SYNC_RUN times}.
    assign w_marker = (r_shift[SYNC_RUN] != r_shift[SYNC_RUN-1]) &&
                      ((r_shift[SYNC_RUN-1:0] == '0) || (r_shift[SYNC_RUN-1:0] == '1));

    // Phase wrap marks the frame boundary; a detect landing here is aligned.
    assign w_sync = (r_phase == PH_LAST);

    always_ff @(posedge clk400) begin
        if (reset) begin
            r_state    <= ST_HUNT;
            r_shift    <= '0;
            r_det      <= 1'b0;
            r_phase    <= '0;
            r_lock_cnt <= '0;
            r_err_cnt  <= '0;
            r_pend     <= 1'b0;
            r_pdata    <= '0;
            r_pvalid   <= 1'b0;
            r_error    <= 1'b0;
            r_locked   <= 1'b0;
        end else if (!enable) begin
            // A strobe raised just before enable fell is dropped, not delayed.
            r_pvalid <= 1'b0;
        end else begin
            r_shift <= {r_shift[SRW-2:0], sdata};
            r_det   <= w_marker;
            // Any marker restarts the phase; an aligned one wraps here anyway.
            r_phase <= (r_det || w_sync) ? '0 : r_phase + 1'b1;

            r_pvalid <= 1'b0;
            // r_shift[0] is already one bit past the frame at this point,
            // because detect is registered one cycle behind the shifter.
            if (w_sync && (r_state != ST_HUNT)) begin
                r_pvalid <= 1'b1;
                r_pdata  <= r_shift[DATA_W:1];
                r_error  <= r_pend;
                r_pend   <= 1'b0;
            end

            if (r_det) begin
                case (r_state)
                    ST_HUNT: begin
                        r_lock_cnt <= 4'd1;
                        if (LOCK_TGT == 4'd1) begin
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                        end else begin
                            r_state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (w_sync) begin
                            r_lock_cnt <= r_lock_cnt + 4'd1;
                            if (r_lock_cnt + 4'd1 == LOCK_TGT) begin
                                r_state  <= ST_LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_lock_cnt <= 4'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_sync) begin
                            r_err_cnt <= '0;
                        end else begin
                            r_pend <= 1'b1;
                            if (r_err_cnt + 4'd1 == ERR_TGT) begin
                                r_state    <= ST_HUNT;
                                r_locked   <= 1'b0;
                                r_err_cnt  <= '0;
                                r_lock_cnt <= '0;
                            end else begin
                                r_err_cnt <= r_err_cnt + 4'd1;
                            end
                        end
                    end
                    default: begin
                        r_state  <= ST_HUNT;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef ERR_COUNT_EN
    logic        w_misaligned;
    logic [15:0] r_err_count;

    assign w_misaligned = r_det && !w_sync;

    always_ff @(posedge clk400) begin
        if (reset || clr_cnt) begin
            r_err_count <= '0;
        end else if (enable && w_misaligned && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign pdata  = r_pdata;
    assign pvalid = r_pvalid & enable;
    assign error  = r_error;
    assign locked = r_locked;

endmodule
